mem_arbiter_ram: RTL and testbench
==================================

Name: mem_arbiter_ram

Overview:
- Parametrised successor to the single-cycle instruction/data RAM used by the processor top.
- Unified word-addressed memory shared by NUM_CH request channels, e.g. ch0 = instruction fetch and ch1 = data load/store.
- Channels use valid/ready handshakes with round-robin arbitration and a configurable read-latency pipeline.
- Supports byte-masked writes and per-request address exceptions; responses return in order on the requesting channel.

Parameters:
- DATA_W, 64, word width in bits; multiple of 8, power of two.
- ADDR_W, 64, byte-address width.
- DEPTH_LOG2, 12, log2 of the number of words in the array.
- NUM_CH, 2, number of request channels; 1..8.
- RD_LAT, 1, cycles from grant to response; 1..4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel grant; combinational from req_valid and the RR pointer.
- req_wren  in  NUM_CH  1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  byte address; channel i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_CH*DATA_W  write data per channel.
- req_mask  in  NUM_CH*DATA_W/8  byte-enable per channel; bit b enables byte b.
- resp_valid  out  NUM_CH  one-cycle response pulse per channel.
- resp_data  out  NUM_CH*DATA_W  read data per channel.
- resp_exc  out  NUM_CH  response carries an address exception.

Behaviour:
- Reset (RESET=0 at a clock edge):
  - All resp_valid, resp_exc and resp_data are cleared to 0.
  - The latency pipeline is flushed; in-flight responses are dropped, never delivered.
  - RR pointer goes to 0.
  - Array contents are NOT cleared.
  - req_ready is 0 while RESET=0.
- Arbitration:
  - At most one grant per cycle.
  - Priority starts at RR pointer p and scans p, p+1, …, NUM_CH-1, 0, … taking the first channel with req_valid=1.
  - req_ready[g]=1 only for the granted g; a transfer occurs when valid and ready are both 1.
  - After a grant to g, p becomes (g+1) mod NUM_CH. With no grant, p is unchanged.
  - Requesters must hold valid and payload stable until ready.
- Address check (index = addr >> log2(DATA_W/8)):
  - A request raises an exception if addr has nonzero low log2(DATA_W/8) bits (misaligned), or if index ≥ 2^DEPTH_LOG2.
  - An exception request performs no array access; its response carries resp_exc=1 and resp_data=0.
- Write:
  - On the grant edge, every byte with mask=1 is updated; other bytes keep their value.
  - mask=0 is a legal no-op write.
  - Response: resp_data=0, resp_exc per the address check.
- Read:
  - The array is sampled on the grant edge; resp_data is that word.
- Latency:
  - A request granted at edge T produces resp_valid on the granted channel for exactly one cycle, visible after edge T+RD_LAT-1 (RD_LAT=1 means the response is visible in the cycle after the grant).
  - The pipeline is RD_LAT deep, carrying channel id, data, exc and valid.
  - A new grant every cycle is supported (full throughput); there is no backpressure on responses.
- Hazards:
  - A read granted the cycle after a write to the same index returns the new merged data.
  - Since only one access occurs per cycle, there are no same-cycle read/write conflicts.
- resp_data for a channel holds its last value when resp_valid=0; only the valid cycle is meaningful.
- Reset mid-operation: a request granted in the same cycle that RESET=0 is discarded (no write, no response).
- With NUM_CH=1, the RR pointer is constant 0 and grant = req_valid & RESET.

Test Plan:
- Reset then write ch1: addr 0x10, data 0x1122334455667788, mask 0xFF; then read ch0 addr 0x10 → RD_LAT after the read grant, resp_valid[0]=1, resp_data 0x1122334455667788, exc 0.
- Partial write ch1: addr 0x10, data 0xAAAAAAAAAAAAAAAA, mask 0x0F; read back → 0x11223344AAAAAAAA.
- Both channels valid continuously for 6 cycles → grants alternate ch0, ch1, ch0, …; one response per cycle; responses arrive on the matching channels in grant order.
- ch1 read addr 0x13 (misaligned), then addr 0x8000 (index 4096 ≥ 4096) → both give resp_exc=1, resp_data=0; array unchanged (verify by re-reading 0x10).
- RESET=0 for one cycle with 3 reads in flight (RD_LAT=4) → no resp_valid for those reads, RR pointer = 0, and the previously written word is still readable after reset.
- RD_LAT=3, NUM_CH=4: back-to-back write then read to addr 0x0 → read returns the new data exactly 3 cycles after its grant.

Source files
------------

// File: rtl/mem_arbiter_ram_if.sv
// Request/response bundle between NUM_CH requesters and the shared word RAM.
// Channel i occupies slice i of every packed vector.
interface mem_arbiter_ram_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);
    localparam int unsigned MASK_W = NUM_CH * (DATA_W / 8);

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_wren;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [MASK_W-1:0]        req_mask;
    logic [NUM_CH-1:0]        resp_valid;
    logic [NUM_CH*DATA_W-1:0] resp_data;
    logic [NUM_CH-1:0]        resp_exc;

    modport master (
        output req_valid, req_wren, req_addr, req_data, req_mask,
        input  req_ready, resp_valid, resp_data, resp_exc
    );

    modport slave (
        input  req_valid, req_wren, req_addr, req_data, req_mask,
        output req_ready, resp_valid, resp_data, resp_exc
    );
endinterface

// File: rtl/mem_arbiter_ram.sv
// Unified word-addressed RAM shared by NUM_CH round-robin-arbitrated channels,
// with byte-masked writes, address exceptions and an RD_LAT-deep response pipe.
module mem_arbiter_ram #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned RD_LAT     = 1
) (
    input logic              CLK,
    input logic              RESET,
    mem_arbiter_ram_if.slave bus
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic              valid;
        logic [CH_W-1:0]   ch;
        logic              exc;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       gnt_ch;
    logic                  gnt;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [BYTES-1:0]      sel_mask;
    logic                  sel_wren;
    logic                  sel_exc;
    logic [DEPTH_LOG2-1:0] sel_idx;
    stage_t                s_in;
    stage_t                s_out;

    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base,
                                                 input int unsigned     ofs);
        int unsigned s;
        s = 32'(base) + ofs;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // First requester at or after the RR pointer wins; nothing is granted in reset.
    always_comb begin
        gnt           = 1'b0;
        gnt_ch        = '0;
        bus.req_ready = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!gnt && RESET && bus.req_valid[rr_index(rr_ptr, k)]) begin
                gnt    = 1'b1;
                gnt_ch = rr_index(rr_ptr, k);
            end
        end
        if (gnt) bus.req_ready[gnt_ch] = 1'b1;
    end

    always_comb begin
        sel_addr   = bus.req_addr[gnt_ch*ADDR_W +: ADDR_W];
        sel_data   = bus.req_data[gnt_ch*DATA_W +: DATA_W];
        sel_mask   = bus.req_mask[gnt_ch*BYTES +: BYTES];
        sel_wren   = bus.req_wren[gnt_ch];
        sel_idx    = DEPTH_LOG2'(sel_addr >> OFF_W);
        sel_exc    = ((sel_addr & ADDR_W'(BYTES - 1)) != '0) ||
                     ((sel_addr >> (OFF_W + DEPTH_LOG2)) != '0);
        s_in.valid = gnt;
        s_in.ch    = gnt_ch;
        s_in.exc   = sel_exc;
        s_in.data  = (sel_wren || sel_exc) ? '0 : mem[sel_idx];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rr_ptr <= '0;
        end else if (gnt) begin
            rr_ptr <= (32'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + CH_W'(1);
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (gnt && sel_wren && !sel_exc) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (sel_mask[b]) mem[sel_idx][b*8 +: 8] <= sel_data[b*8 +: 8];
            end
        end
    end

    // RD_LAT-1 pipe stages feed the per-channel output registers (the last stage).
    if (RD_LAT == 1) begin : g_direct
        assign s_out = s_in;
    end else begin : g_pipe
        stage_t pipe [RD_LAT-1];

        always_ff @(posedge CLK) begin
            if (!RESET) begin
                for (int unsigned i = 0; i < RD_LAT - 1; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= s_in;
                for (int unsigned i = 1; i < RD_LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign s_out = pipe[RD_LAT-2];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bus.resp_valid <= '0;
            bus.resp_exc   <= '0;
            bus.resp_data  <= '0;
        end else begin
            bus.resp_valid <= '0;
            if (s_out.valid) begin
                bus.resp_valid[s_out.ch]                   <= 1'b1;
                bus.resp_exc[s_out.ch]                     <= s_out.exc;
                bus.resp_data[s_out.ch*DATA_W +: DATA_W]   <= s_out.data;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_ram.sv
// Directed bench: dut_a (2 ch, RD_LAT 1), dut_b (2 ch, RD_LAT 4) for reset
// flushing, dut_c (4 ch, RD_LAT 3) for back-to-back hazard and 4-way round robin.
module tb_mem_arbiter_ram;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    mem_arbiter_ram_if #(.NUM_CH(2), .DATA_W(64), .ADDR_W(64)) ifa ();
    mem_arbiter_ram_if #(.NUM_CH(2), .DATA_W(64), .ADDR_W(64)) ifb ();
    mem_arbiter_ram_if #(.NUM_CH(4), .DATA_W(64), .ADDR_W(64)) ifc ();

    mem_arbiter_ram #(.DATA_W(64), .ADDR_W(64), .DEPTH_LOG2(12), .NUM_CH(2), .RD_LAT(1))
        dut_a (.CLK(clk), .RESET(rst_a), .bus(ifa.slave));
    mem_arbiter_ram #(.DATA_W(64), .ADDR_W(64), .DEPTH_LOG2(8), .NUM_CH(2), .RD_LAT(4))
        dut_b (.CLK(clk), .RESET(rst_b), .bus(ifb.slave));
    mem_arbiter_ram #(.DATA_W(64), .ADDR_W(64), .DEPTH_LOG2(8), .NUM_CH(4), .RD_LAT(3))
        dut_c (.CLK(clk), .RESET(rst_c), .bus(ifc.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        ifa.req_valid = '0;
        ifa.req_wren  = '0;
        ifa.req_addr  = '0;
        ifa.req_data  = '0;
        ifa.req_mask  = '0;
    endtask

    task automatic a_drive(input int ch, input logic wr, input logic [63:0] addr,
                           input logic [63:0] data, input logic [7:0] mask);
        a_idle();
        ifa.req_valid[ch]          = 1'b1;
        ifa.req_wren[ch]           = wr;
        ifa.req_addr[ch*64 +: 64]  = addr;
        ifa.req_data[ch*64 +: 64]  = data;
        ifa.req_mask[ch*8 +: 8]    = mask;
    endtask

    // One isolated transfer on dut_a with its RD_LAT=1 response check.
    task automatic a_xfer(input string tag, input int ch, input logic wr,
                          input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] mask, input logic [63:0] exp_data,
                          input logic exp_exc);
        logic [1:0] oh;
        oh = 2'(1) << ch;
        @(negedge clk);
        a_drive(ch, wr, addr, data, mask);
        #1;
        chk({tag, "/ready"}, 64'(ifa.req_ready), 64'(oh));
        @(posedge clk);
        #1 a_idle();
        @(negedge clk);
        chk({tag, "/rvalid"}, 64'(ifa.resp_valid), 64'(oh));
        chk({tag, "/rdata"}, ifa.resp_data[ch*64 +: 64], exp_data);
        chk({tag, "/rexc"}, 64'(ifa.resp_exc[ch]), 64'(exp_exc));
    endtask

    logic [3:0] exp_c [7];

    initial begin
        checks   = 0;
        failures = 0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        rst_c    = 1'b0;
        a_idle();
        ifb.req_valid = '0; ifb.req_wren = '0; ifb.req_addr = '0;
        ifb.req_data  = '0; ifb.req_mask = '0;
        ifc.req_valid = '0; ifc.req_wren = '0; ifc.req_addr = '0;
        ifc.req_data  = '0; ifc.req_mask = '0;
        exp_c[0] = 4'b0001; exp_c[1] = 4'b0010; exp_c[2] = 4'b0100; exp_c[3] = 4'b1000;
        exp_c[4] = 4'b0010; exp_c[5] = 4'b1000; exp_c[6] = 4'b0010;

        // ---------------- dut_a: reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 2'b11;
        #1;
        chk("a_rst/ready", 64'(ifa.req_ready), 64'h0);
        chk("a_rst/rvalid", 64'(ifa.resp_valid), 64'h0);
        chk("a_rst/rexc", 64'(ifa.resp_exc), 64'h0);
        chk("a_rst/rdata0", ifa.resp_data[63:0], 64'h0);
        a_idle();
        @(negedge clk);
        rst_a = 1'b1;

        // ---------------- dut_a: full and partial writes ----------------
        a_xfer("a_wr_full", 1, 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0);
        a_xfer("a_rd_full", 0, 1'b0, 64'h10, 64'h0, 8'h00, 64'h1122334455667788, 1'b0);
        a_xfer("a_wr_18", 0, 1'b1, 64'h18, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0);
        a_xfer("a_wr_part", 1, 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0);
        a_xfer("a_rd_part", 1, 1'b0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);

        // ---------------- dut_a: both channels requesting for 6 cycles ----------------
        @(negedge clk);
        ifa.req_valid          = 2'b11;
        ifa.req_addr[0 +: 64]  = 64'h18;
        ifa.req_addr[64 +: 64] = 64'h10;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("a_rr/ready", 64'(ifa.req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    chk("a_rr/rvalid", 64'(ifa.resp_valid), 64'h1);
                    chk("a_rr/rdata0", ifa.resp_data[0 +: 64], 64'hDEADBEEFCAFEF00D);
                end else begin
                    chk("a_rr/rvalid", 64'(ifa.resp_valid), 64'h2);
                    chk("a_rr/rdata1", ifa.resp_data[64 +: 64], 64'h11223344AAAAAAAA);
                end
            end
            @(negedge clk);
        end
        #1;
        chk("a_rr/rvalid_last", 64'(ifa.resp_valid), 64'h2);
        chk("a_rr/rdata_last", ifa.resp_data[64 +: 64], 64'h11223344AAAAAAAA);
        a_idle();

        // ---------------- dut_a: address exceptions and no-op write ----------------
        a_xfer("a_rd_mis", 1, 1'b0, 64'h13, 64'h0, 8'h00, 64'h0, 1'b1);
        a_xfer("a_rd_oob", 1, 1'b0, 64'h8000, 64'h0, 8'h00, 64'h0, 1'b1);
        a_xfer("a_wr_mis", 1, 1'b1, 64'h13, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1);
        a_xfer("a_wr_oob", 1, 1'b1, 64'h8010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1);
        a_xfer("a_wr_nomask", 0, 1'b1, 64'h10, 64'h0, 8'h00, 64'h0, 1'b0);
        a_xfer("a_rd_after", 0, 1'b0, 64'h10, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0);
        a_xfer("a_rd_exc1", 1, 1'b0, 64'h14, 64'h0, 8'h00, 64'h0, 1'b1);

        // ---------------- dut_a: reset clears response registers ----------------
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_rst2/rdata0", ifa.resp_data[0 +: 64], 64'h0);
        chk("a_rst2/rexc", 64'(ifa.resp_exc), 64'h0);
        rst_a = 1'b1;

        // ---------------- dut_b: reset flushes in-flight reads ----------------
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        ifb.req_valid          = 2'b01;
        ifb.req_wren           = 2'b01;
        ifb.req_addr[0 +: 64]  = 64'h20;
        ifb.req_data[0 +: 64]  = 64'h0123456789ABCDEF;
        ifb.req_mask           = 16'h00FF;
        #1;
        chk("b_wr/ready", 64'(ifb.req_ready), 64'h1);
        @(posedge clk);
        #1;
        ifb.req_valid = '0; ifb.req_wren = '0; ifb.req_data = '0; ifb.req_mask = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b_wr/rvalid", 64'(ifb.resp_valid), (k == 3) ? 64'h1 : 64'h0);
        end
        @(negedge clk);
        ifb.req_valid = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("b_flush/ready_in_rst", 64'(ifb.req_ready), 64'h0);
        chk("b_flush/rvalid_pre", 64'(ifb.resp_valid), 64'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ifb.req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b_flush/rvalid", 64'(ifb.resp_valid), 64'h0);
        end
        @(negedge clk);
        ifb.req_valid           = 2'b11;
        ifb.req_addr[64 +: 64]  = 64'h20;
        #1;
        chk("b_ptr/ready", 64'(ifb.req_ready), 64'h1);
        @(posedge clk);
        #1 ifb.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b_ptr/rvalid", 64'(ifb.resp_valid), (k == 3) ? 64'h1 : 64'h0);
        end
        chk("b_ptr/rdata", ifb.resp_data[0 +: 64], 64'h0123456789ABCDEF);

        // ---------------- dut_c: back-to-back write then read, RD_LAT 3 ----------------
        @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        ifc.req_valid            = 4'b0100;
        ifc.req_wren             = 4'b0100;
        ifc.req_data[128 +: 64]  = 64'hCAFEBABE12345678;
        ifc.req_mask[16 +: 8]    = 8'hFF;
        #1;
        chk("c_wr/ready", 64'(ifc.req_ready), 64'h4);
        @(posedge clk);
        #1;
        ifc.req_valid = 4'b1000; ifc.req_wren = '0; ifc.req_data = '0; ifc.req_mask = '0;
        @(negedge clk);
        chk("c_rd/ready", 64'(ifc.req_ready), 64'h8);
        @(posedge clk);
        #1 ifc.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("c_b2b/rvalid", 64'(ifc.resp_valid),
                (k == 1) ? 64'h4 : ((k == 2) ? 64'h8 : 64'h0));
            if (k == 2) begin
                chk("c_b2b/rdata", ifc.resp_data[192 +: 64], 64'hCAFEBABE12345678);
                chk("c_b2b/rexc", 64'(ifc.resp_exc[3]), 64'h0);
            end
        end

        // ---------------- dut_c: 4-way round robin then sparse requesters ----------------
        @(negedge clk);
        ifc.req_valid = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) ifc.req_valid = 4'b1010;
            #1;
            chk("c_rr/ready", 64'(ifc.req_ready), 64'(exp_c[i]));
            @(negedge clk);
        end
        ifc.req_valid = '0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
